// File: rtl/minimal_mem_master.sv
// Single-channel initiator for the Bambu minimal memory interface.
// Takes one client command at a time, holds it on the bus until the responder
// strobes M_DataRdy, then returns a one-cycle response pulse.
// Optional feature: define MEM_MASTER_TIMEOUT_EN to abort accesses that stay
// BUSY for TIMEOUT_CYCLES cycles (response flagged with rsp_error=1).

module minimal_mem_master #(
    parameter int unsigned ADDR_W         = 13,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned SIZE_W         = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [SIZE_W-1:0] cmd_size,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              Mout_oe_ram,
    output logic              Mout_we_ram,
    output logic [ADDR_W-1:0] Mout_addr_ram,
    output logic [DATA_W-1:0] Mout_Wdata_ram,
    output logic [SIZE_W-1:0] Mout_data_ram_size,
    input  logic [DATA_W-1:0] M_Rdata_ram,
    input  logic              M_DataRdy
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] rd_mask;

`ifdef MEM_MASTER_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        err_q;
    logic        timeout;

    assign timeout   = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign rsp_error = err_q;
`else
    // Parameter only matters for the timeout build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign rsp_error          = 1'b0;
`endif

    // Keep the low cmd_size bits of read data; sizes >= DATA_W leave all bits.
    // The bus size register still holds the access size while BUSY.
    always_comb begin
        rd_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rd_mask[i] = (i < int'(Mout_data_ram_size));
        end
    end

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= StIdle;
            cmd_ready          <= 1'b1;
            rsp_valid          <= 1'b0;
            rsp_rdata          <= '0;
            Mout_oe_ram        <= 1'b0;
            Mout_we_ram        <= 1'b0;
            Mout_addr_ram      <= '0;
            Mout_Wdata_ram     <= '0;
            Mout_data_ram_size <= '0;
`ifdef MEM_MASTER_TIMEOUT_EN
            cnt_q              <= '0;
            err_q              <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // cmd_ready is always 1 here, so cmd_valid alone is the handshake.
                    if (cmd_valid) begin
                        Mout_oe_ram        <= ~cmd_we;
                        Mout_we_ram        <= cmd_we;
                        Mout_addr_ram      <= cmd_addr;
                        Mout_Wdata_ram     <= cmd_we ? cmd_wdata : '0;
                        Mout_data_ram_size <= cmd_size;
                        cmd_ready          <= 1'b0;
                        state_q            <= StBusy;
`ifdef MEM_MASTER_TIMEOUT_EN
                        cnt_q              <= '0;
`endif
                    end
                end
                StBusy: begin
                    if (M_DataRdy) begin
                        Mout_oe_ram        <= 1'b0;
                        Mout_we_ram        <= 1'b0;
                        Mout_addr_ram      <= '0;
                        Mout_Wdata_ram     <= '0;
                        Mout_data_ram_size <= '0;
                        rsp_valid          <= 1'b1;
                        rsp_rdata          <= Mout_we_ram ? '0 : (M_Rdata_ram & rd_mask);
                        state_q            <= StResp;
`ifdef MEM_MASTER_TIMEOUT_EN
                        err_q              <= 1'b0;
                    end else if (timeout) begin
                        Mout_oe_ram        <= 1'b0;
                        Mout_we_ram        <= 1'b0;
                        Mout_addr_ram      <= '0;
                        Mout_Wdata_ram     <= '0;
                        Mout_data_ram_size <= '0;
                        rsp_valid          <= 1'b1;
                        rsp_rdata          <= '0;
                        err_q              <= 1'b1;
                        state_q            <= StResp;
                    end else begin
                        cnt_q              <= cnt_q + 16'd1;
`endif
                    end
                end
                StResp: begin
                    cmd_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minimal_mem_master.sv
// Bench for minimal_mem_master: table-driven accesses through a bus responder
// model with programmable DataRdy delay, scoreboard of expected responses,
// plus hand-written back-to-back, reset-mid-access and timeout sequences.

module tb_minimal_mem_master;

    localparam int TO = 8;

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [5:0]  size;
        int          delay;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [5:0]  size;
        int          acc;
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [12:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [5:0]  cmd_size = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        Mout_oe_ram;
    logic        Mout_we_ram;
    logic [12:0] Mout_addr_ram;
    logic [31:0] Mout_Wdata_ram;
    logic [5:0]  Mout_data_ram_size;
    logic [31:0] M_Rdata_ram;
    logic        M_DataRdy;

    logic [31:0] mem [0:8191];
    int          rsp_delay = 1;  // 0 = responder never answers
    int          busy_cnt = 0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          rsp_cnt = 0;
    exp_t        exp_q[$];

    minimal_mem_master #(
        .ADDR_W(13), .DATA_W(32), .SIZE_W(6), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_we             (cmd_we),
        .cmd_addr           (cmd_addr),
        .cmd_wdata          (cmd_wdata),
        .cmd_size           (cmd_size),
        .rsp_valid          (rsp_valid),
        .rsp_rdata          (rsp_rdata),
        .rsp_error          (rsp_error),
        .Mout_oe_ram        (Mout_oe_ram),
        .Mout_we_ram        (Mout_we_ram),
        .Mout_addr_ram      (Mout_addr_ram),
        .Mout_Wdata_ram     (Mout_Wdata_ram),
        .Mout_data_ram_size (Mout_data_ram_size),
        .M_Rdata_ram        (M_Rdata_ram),
        .M_DataRdy          (M_DataRdy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Responder: DataRdy in the rsp_delay-th cycle of a request.
    always @(posedge clock) begin
        if (reset || !(Mout_oe_ram || Mout_we_ram)) busy_cnt <= 0;
        else                                        busy_cnt <= busy_cnt + 1;
    end
    assign M_DataRdy   = (Mout_oe_ram || Mout_we_ram) && (busy_cnt + 1 == rsp_delay);
    assign M_Rdata_ram = mem[Mout_addr_ram];

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    // Monitor: bus protocol checks, memory writes, scoreboard compare.
    initial begin : monitor
        logic        prev_active;
        logic [12:0] prev_addr;
        logic        active;
        exp_t        e;
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        mem[13'h040] = 32'hDEADBEEF;
        mem[13'h020] = 32'hAABBCCDD;
        mem[13'h044] = 32'hCAFEF00D;
        mem[13'h010] = 32'hFFFFFFFF;
        prev_active = 1'b0;
        prev_addr   = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_active = 1'b0;
            end else begin
                active = Mout_oe_ram | Mout_we_ram;
                if (Mout_oe_ram && Mout_we_ram) check("oe_we_exclusive", 32'd1, 32'd0);
                if (active) check("ready_low_busy", 32'(cmd_ready), 32'd0);
                if (active && prev_active) check("addr_stable", 32'(Mout_addr_ram), 32'(prev_addr));
                if (active && !prev_active) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_request", 32'd1, 32'd0);
                    end else begin
                        e = exp_q[0];
                        check("req_cycle", 32'(cyc), 32'(e.acc + 1));
                        check("req_oe", 32'(Mout_oe_ram), 32'(!e.we));
                        check("req_we", 32'(Mout_we_ram), 32'(e.we));
                        check("req_addr", 32'(Mout_addr_ram), 32'(e.addr));
                        check("req_wdata", Mout_Wdata_ram, e.wdata);
                        check("req_size", 32'(Mout_data_ram_size), 32'(e.size));
                    end
                end
                if (Mout_we_ram && M_DataRdy) mem[Mout_addr_ram] = Mout_Wdata_ram;
                if (rsp_valid) begin
                    rsp_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_cycle", 32'(cyc), 32'(e.acc + e.lat));
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_error", 32'(rsp_error), 32'(e.err));
                        check("rsp_bus_idle", 32'(active), 32'd0);
                        check("rsp_addr_clr", 32'(Mout_addr_ram), 32'd0);
                    end
                end
                prev_active = active;
                prev_addr   = Mout_addr_ram;
            end
        end
    end

    // Present a command and hold it until accepted; leaves cmd_valid high.
    task automatic issue(input vec_t v, input int lat, input logic err);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_size  = v.size;
        while (!cmd_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            rsp_delay = v.delay;
            e.we    = v.we;
            e.addr  = v.addr;
            e.wdata = v.we ? v.wdata : 32'h0;
            e.size  = v.size;
            e.acc   = cyc;
            e.lat   = lat;
            e.rdata = v.rdata;
            e.err   = err;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clock);
        cmd_valid = 1'b0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("rsp_wait_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[7];
        vec_t v;
        int   base;
        vecs[0] = '{1'b0, 13'h040, 32'h0,        6'd32, 2, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 13'h010, 32'h12345678, 6'd32, 1, 32'h0};
        vecs[2] = '{1'b0, 13'h010, 32'h0,        6'd32, 1, 32'h12345678};
        vecs[3] = '{1'b0, 13'h020, 32'h0,        6'd8,  3, 32'h000000DD};
        vecs[4] = '{1'b0, 13'h020, 32'h0,        6'd16, 1, 32'h0000CCDD};
        vecs[5] = '{1'b1, 13'h044, 32'h0BADF00D, 6'd16, 4, 32'h0};
        // DataRdy on the last cycle before a timeout must still win.
        vecs[6] = '{1'b0, 13'h044, 32'h0,        6'd32, TO, 32'h0BADF00D};

        // Reset values
        repeat (2) @(negedge clock);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_oe", 32'(Mout_oe_ram), 32'd0);
        check("rst_we", 32'(Mout_we_ram), 32'd0);
        check("rst_addr", 32'(Mout_addr_ram), 32'd0);
        check("rst_wdata", Mout_Wdata_ram, 32'd0);
        check("rst_size", 32'(Mout_data_ram_size), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        reset = 1'b0;

        // Table of single accesses
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i], vecs[i].delay + 1, 1'b0);
            drain();
        end

        // Back-to-back reads with cmd_valid held high
        base = rsp_cnt;
        v = '{1'b0, 13'h040, 32'h0, 6'd32, 1, 32'hDEADBEEF};
        issue(v, 2, 1'b0);
        v = '{1'b0, 13'h020, 32'h0, 6'd8, 2, 32'h000000DD};
        issue(v, 3, 1'b0);
        v = '{1'b0, 13'h044, 32'h0, 6'd32, 3, 32'h0BADF00D};
        issue(v, 4, 1'b0);
        drain();
        check("b2b_rsp_count", 32'(rsp_cnt - base), 32'd3);

        // Reset in the middle of a stalled access
        base = rsp_cnt;
        v = '{1'b0, 13'h040, 32'h0, 6'd32, 0, 32'h0};
        issue(v, 1, 1'b0);
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("stall_oe_held", 32'(Mout_oe_ram), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_oe", 32'(Mout_oe_ram), 32'd0);
        check("midrst_we", 32'(Mout_we_ram), 32'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        rsp_delay = 1;
        @(negedge clock);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        repeat (4) @(negedge clock);
        check("midrst_no_rsp", 32'(rsp_cnt - base), 32'd0);
        v = '{1'b0, 13'h040, 32'h0, 6'd32, 2, 32'hDEADBEEF};
        issue(v, 3, 1'b0);
        drain();

`ifdef MEM_MASTER_TIMEOUT_EN
        // Responder never answers: abort after TO busy cycles
        v = '{1'b0, 13'h020, 32'h0, 6'd32, 0, 32'h0};
        issue(v, TO + 1, 1'b1);
        drain();
        rsp_delay = 1;
        v = '{1'b0, 13'h020, 32'h0, 6'd32, 1, 32'hAABBCCDD};
        issue(v, 2, 1'b0);
        drain();
`endif

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
